tt_sel_driver: RTL and testbench

TT_SEL_DRIVER -- requirements
Module: tt_sel_driver

---
 rtl/tt_sel_driver.sv | 159 +++++++++++++++
 tb/tb_tt_sel_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sel_driver.sv
// Drives the mux select lines: address-counter reset pulse, N increment strobes, then design enable.
// Optional macro TT_SEL_SKIP_RESET_EN: reuse the shadow address and only step forward when possible.
module tt_sel_driver #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] target_addr,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, RST_LO, RST_HI, INC_HI, INC_LO, ENABLE} state_t;

  localparam logic [7:0]        PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [7:0]        tmr_q, tmr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              valid_q, valid_d;
  logic              rst_n_q, rst_n_d;
  logic              inc_q, inc_d;
  logic              ena_q, ena_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmr_end;

  assign tmr_end = (tmr_q == '0);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    cur_addr_d = cur_addr_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE, ENABLE: begin
        if (start) begin
          valid_d = 1'b0;
          tmr_d   = PULSE_LAST;
`ifdef TT_SEL_SKIP_RESET_EN
          if (valid_q && (target_addr >= cur_addr_q)) begin
            // Counter already holds cur_addr: step forward by the difference only.
            cnt_d = target_addr - cur_addr_q;
            if (target_addr == cur_addr_q) begin
              state_d = ENABLE;
              valid_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = INC_HI;
            end
          end else begin
            cnt_d   = target_addr;
            state_d = RST_LO;
          end
`else
          cnt_d   = target_addr;
          state_d = RST_LO;
`endif
        end
      end
      RST_LO: begin
        if (tmr_end) begin
          state_d    = RST_HI;
          tmr_d      = PULSE_LAST;
          cur_addr_d = '0;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      RST_HI: begin
        if (tmr_end) begin
          tmr_d = PULSE_LAST;
          if (cnt_q == '0) begin
            state_d = ENABLE;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = INC_HI;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      INC_HI: begin
        if (tmr_end) begin
          state_d    = INC_LO;
          tmr_d      = PULSE_LAST;
          cur_addr_d = cur_addr_q + ONE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      INC_LO: begin
        if (tmr_end) begin
          tmr_d = PULSE_LAST;
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_d = ENABLE;
            valid_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = INC_HI;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register in step with it.
    rst_n_d = !((state_d == IDLE) || (state_d == RST_LO));
    inc_d   = (state_d == INC_HI);
    ena_d   = (state_d == ENABLE);
    busy_d  = (state_d == RST_LO) || (state_d == RST_HI) ||
              (state_d == INC_HI) || (state_d == INC_LO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      cnt_q      <= '0;
      cur_addr_q <= '0;
      valid_q    <= 1'b0;
      rst_n_q    <= 1'b0;
      inc_q      <= 1'b0;
      ena_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      cur_addr_q <= cur_addr_d;
      valid_q    <= valid_d;
      rst_n_q    <= rst_n_d;
      inc_q      <= inc_d;
      ena_q      <= ena_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ctrl_sel_rst_n = rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_tt_sel_driver.sv
// Bench for tt_sel_driver: table of selections plus hand sequences, scoreboarded at done.
module tb_tt_sel_driver;

  localparam int unsigned AW = 10;
  localparam int P = 2;

  typedef struct {
    logic [AW-1:0] tgt;
    int            incs;
    int            rstlo;
    int            lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] target_addr = '0;
  logic          rst_n, inc, ena, busy, done;

  int checks = 0;
  int failures = 0;

  vec_t sb[$];
  vec_t tbl[6];

  tt_sel_driver #(.ADDR_W(AW), .PULSE_CYC(P)) dut (
    .clk(clk), .rst(rst), .start(start), .target_addr(target_addr),
    .ctrl_sel_rst_n(rst_n), .ctrl_sel_inc(inc), .ctrl_ena(ena),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Monitor: invariants every cycle, and per-sequence measurements popped against the scoreboard.
  logic busy_p = 1'b0, inc_p = 1'b0, done_p = 1'b0;
  int cyc, n_inc, hi_run, lo_run, rst_lo;
  bit active = 1'b0, seen_inc;
  vec_t e;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
    end else begin
      chk("inv_inc_and_ena", int'(inc && ena), 0);
      chk("inv_inc_in_rst", int'(inc && !rst_n), 0);
      if (busy && !busy_p) begin
        active = 1'b1; cyc = 0; n_inc = 0; hi_run = 0; lo_run = 0; rst_lo = 0; seen_inc = 1'b0;
      end else if (active) begin
        cyc++;
      end
      if (active) begin
        if (inc && !inc_p) begin
          n_inc++;
          if (seen_inc) chk("inc_lo_width", lo_run, P);
          hi_run = 0;
        end
        if (!inc && inc_p) begin
          chk("inc_hi_width", hi_run, P);
          lo_run = 0;
          seen_inc = 1'b1;
        end
        if (inc) hi_run++;
        else if (seen_inc && !done) lo_run++;
        if (!rst_n) rst_lo++;
      end
      if (done) begin
        if (done_p) chk("done_width", 2, 1);
        chk("ena_at_done", int'(ena), 1);
        chk("busy_at_done", int'(busy), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          if (!active) begin
            chk("busy_never_rose", 0, 1);
          end else begin
            chk("inc_count", n_inc, e.incs);
            chk("rst_lo_cycles", rst_lo, e.rstlo);
            chk("latency", cyc, e.lat);
            if (seen_inc) chk("last_inc_lo_width", lo_run, P);
          end
        end
        active = 1'b0;
      end
    end
    busy_p = busy; inc_p = inc; done_p = done;
  end

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk({name, "_timeout"}, 0, 1);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic sel(input logic [AW-1:0] tgt, input vec_t exp_v, input string name);
    @(negedge clk); #1;
    start = 1'b1; target_addr = tgt;
    sb.push_back(exp_v);
    @(negedge clk); #1;
    start = 1'b0;
    wait_done(name);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_inc_rise(input int k, input string name);
    int seen = 0;
    logic prev = inc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (inc && !prev) seen++;
      prev = inc;
      if (seen == k) break;
    end
    chk({name, "_inc_rise"}, seen, k);
  endtask

  function automatic vec_t mk(logic [AW-1:0] t, int n, int r, int l);
    vec_t v;
    v.tgt = t; v.incs = n; v.rstlo = r; v.lat = l;
    return v;
  endfunction

  initial begin
`ifdef TT_SEL_SKIP_RESET_EN
    tbl[0] = mk(10'd3,    3,    P, 16);
    tbl[1] = mk(10'd0,    0,    P, 4);
    tbl[2] = mk(10'd1,    1,    0, 4);
    tbl[3] = mk(10'd5,    4,    0, 16);
    tbl[4] = mk(10'd2,    2,    P, 12);
    tbl[5] = mk(10'd1023, 1021, 0, 4084);
`else
    tbl[0] = mk(10'd3,    3,    P, 16);
    tbl[1] = mk(10'd0,    0,    P, 4);
    tbl[2] = mk(10'd1,    1,    P, 8);
    tbl[3] = mk(10'd5,    5,    P, 24);
    tbl[4] = mk(10'd2,    2,    P, 12);
    tbl[5] = mk(10'd1023, 1023, P, 4096);
`endif

    // Reset state, and rst_n held low in IDLE before any start.
    repeat (3) @(negedge clk);
    chk("rst_rst_n", int'(rst_n), 0);
    chk("rst_inc", int'(inc), 0);
    chk("rst_ena", int'(ena), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rst_n_low", int'(rst_n), 0);
      chk("idle_busy", int'(busy), 0);
    end

    for (int i = 0; i < 6; i++) sel(tbl[i].tgt, tbl[i], "table");

    // Select 3 then 5 then 2.
    do_reset();
    sel(10'd3, mk(10'd3, 3, P, 16), "sel3");
`ifdef TT_SEL_SKIP_RESET_EN
    sel(10'd5, mk(10'd5, 2, 0, 8), "sel5_skip");
`else
    sel(10'd5, mk(10'd5, 5, P, 24), "sel5_full");
`endif
    sel(10'd2, mk(10'd2, 2, P, 12), "sel2_full");

    // Start during INC_HI is ignored.
    do_reset();
    @(negedge clk); #1;
    start = 1'b1; target_addr = 10'd3;
    sb.push_back(mk(10'd3, 3, P, 16));
    @(negedge clk); #1 start = 1'b0;
    wait_inc_rise(1, "ignore");
    #1 start = 1'b1; target_addr = 10'd7;
    @(negedge clk); #1 start = 1'b0;
    wait_done("ignore");

    // Reset during the second INC_HI aborts with no done.
    do_reset();
    @(negedge clk); #1;
    start = 1'b1; target_addr = 10'd3;
    sb.push_back(mk(10'd3, 3, P, 16));
    @(negedge clk); #1 start = 1'b0;
    wait_inc_rise(2, "abort");
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_n", int'(rst_n), 0);
    chk("abort_inc", int'(inc), 0);
    chk("abort_ena", int'(ena), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    #1 rst = 1'b0;
    sb.delete();
    repeat (20) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
      chk("abort_idle_busy", int'(busy), 0);
    end

    // Reset wins over a simultaneous start.
    @(negedge clk); #1;
    rst = 1'b1; start = 1'b1; target_addr = 10'd5;
    @(negedge clk);
    chk("prio_busy", int'(busy), 0);
    chk("prio_rst_n", int'(rst_n), 0);
    #1 rst = 1'b0; start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("prio_stays_idle", int'(busy), 0);
    end

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
